// File: rtl/miner_regs_defs.sv
// Shared constants for the siaminer internal-bus register block:
// address map, CTRL/STATUS bit positions and block sizes.
package miner_regs_defs;

   localparam int HDR_BYTES    = 80;
   localparam int TARGET_BYTES = 8;

   localparam logic [11:0] A_HDR   = 12'h000;
   localparam logic [11:0] A_TGT   = 12'h050;
   localparam logic [11:0] A_CTRL  = 12'h060;
   localparam logic [11:0] A_STAT  = 12'h061;
   localparam logic [11:0] A_CNT   = 12'h062;
   localparam logic [11:0] A_NONCE = 12'h068;

   localparam int CTRL_START = 0;
   localparam int CTRL_STOP  = 1;
   localparam int CTRL_CLR   = 2;

   localparam int ST_BUSY  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_WWB   = 4;

endpackage

// File: rtl/miner_regs_if.sv
// Byte-wide, 16-bit-addressed internal bus between the UART parser
// (master) and the register block (slave).
interface miner_regs_if;

   logic        int_req;
   logic        int_gnt;
   logic [15:0] int_address;
   logic [7:0]  int_wr_data;
   logic        int_write;
   logic        int_read;
   logic [7:0]  int_rd_data;

   modport master (
      output int_req,
      output int_address,
      output int_wr_data,
      output int_write,
      output int_read,
      input  int_gnt,
      input  int_rd_data
   );

   modport slave (
      input  int_req,
      input  int_address,
      input  int_wr_data,
      input  int_write,
      input  int_read,
      output int_gnt,
      output int_rd_data
   );

endinterface

// File: rtl/nonce_fifo.sv
// Found-nonce FIFO: 64-bit entries, power-of-two depth, pointers
// wrap naturally; clear dominates any same-cycle push or pop.
module nonce_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic [63:0]              din,
   output logic [63:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rp];

   // A pop frees the head slot, so a full FIFO may still accept a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clr) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wp <= wp + 1'b1;
         if (do_pop)
            rp <= rp + 1'b1;
         if (do_push & ~do_pop)
            count <= count + 1'b1;
         else if (do_pop & ~do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~clr)
         mem[wp] <= din;
   end

endmodule

// File: rtl/miner_regs.sv
// siaminer register block: bus decode, header/target storage,
// start/stop pulses, sticky error bits and the found-nonce FIFO.
module miner_regs
   import miner_regs_defs::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   miner_regs_if.slave               bus,
   output logic [HDR_BYTES*8-1:0]    hdr,
   output logic [TARGET_BYTES*8-1:0] target,
   output logic                      start,
   output logic                      stop,
   input  logic                      core_busy,
   input  logic                      nonce_found,
   input  logic [63:0]               nonce_in
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [11:0]   a;
   logic          mapped;
   logic          is_hdr;
   logic          is_tgt;
   logic          is_ctrl;
   logic          is_stat;
   logic          is_cnt;
   logic          is_nonce;
   logic          wr;
   logic          rd;
   logic [7:0]    wd;
   logic [9:0]    hoff;
   logic [5:0]    boff;

   logic          gnt_q;
   logic [7:0]    rd_q;
   logic [7:0]    rd_val;
   logic          ovf;
   logic          wwb;
   logic          ovf_set;
   logic          wwb_set;

   logic          f_pop;
   logic          f_clr;
   logic [63:0]   f_dout;
   logic          f_full;
   logic          f_empty;
   logic [CW-1:0] f_count;

   assign a      = bus.int_address[11:0];
   assign mapped = (bus.int_address[15:12] == 4'h0);
   assign wr     = bus.int_write;
   assign rd     = bus.int_read;
   assign wd     = bus.int_wr_data;

   assign is_hdr   = mapped && (a < A_HDR + 12'(HDR_BYTES));
   assign is_tgt   = mapped && (a >= A_TGT)
                     && (a < A_TGT + 12'(TARGET_BYTES));
   assign is_ctrl  = mapped && (a == A_CTRL);
   assign is_stat  = mapped && (a == A_STAT);
   assign is_cnt   = mapped && (a == A_CNT);
   assign is_nonce = mapped && (a[11:3] == A_NONCE[11:3]);

   assign hoff = {a[6:0], 3'b000};
   assign boff = {a[2:0], 3'b000};

   // Only the last head byte pops, after the head has been returned.
   assign f_pop = rd & is_nonce & (a[2:0] == 3'd7) & ~f_empty;
   assign f_clr = wr & is_ctrl & wd[CTRL_CLR];

   assign ovf_set = nonce_found & f_full & ~f_pop;
   assign wwb_set = wr & core_busy
                    & (is_hdr | is_tgt | (is_ctrl & wd[CTRL_START]));

   assign bus.int_gnt     = gnt_q;
   assign bus.int_rd_data = rd_q;

   nonce_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (nonce_found),
      .pop   (f_pop),
      .clr   (f_clr),
      .din   (nonce_in),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_comb begin
      rd_val = 8'h00;
      unique case (1'b1)
         is_hdr:   rd_val = hdr[hoff +: 8];
         is_tgt:   rd_val = target[boff +: 8];
         is_stat: begin
            rd_val[ST_BUSY]  = core_busy;
            rd_val[ST_EMPTY] = f_empty;
            rd_val[ST_FULL]  = f_full;
            rd_val[ST_OVF]   = ovf;
            rd_val[ST_WWB]   = wwb;
         end
         is_cnt:   rd_val = 8'(f_count);
         is_nonce: rd_val = f_empty ? 8'h00 : f_dout[boff +: 8];
         default:  rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q  <= 1'b0;
         rd_q   <= 8'h00;
         start  <= 1'b0;
         stop   <= 1'b0;
         hdr    <= '0;
         target <= '0;
         ovf    <= 1'b0;
         wwb    <= 1'b0;
      end else begin
         gnt_q <= bus.int_req;
         start <= 1'b0;
         stop  <= 1'b0;
         if (rd)
            rd_q <= rd_val;
         if (wr & ~core_busy & is_hdr)
            hdr[hoff +: 8] <= wd;
         if (wr & ~core_busy & is_tgt)
            target[boff +: 8] <= wd;
         // Stop always wins over a same-write start request.
         if (wr & is_ctrl) begin
            stop  <= wd[CTRL_STOP];
            start <= wd[CTRL_START] & ~wd[CTRL_STOP] & ~core_busy;
         end
         if (f_clr) begin
            ovf <= 1'b0;
            wwb <= 1'b0;
         end else begin
            if (ovf_set)
               ovf <= 1'b1;
            if (wwb_set)
               wwb <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_miner_regs.sv
// Directed bench for miner_regs: reads go through a scoreboard queue,
// FIFO and sticky bits are tracked by a small bench-side model.
module tb_miner_regs;
   import miner_regs_defs::*;

   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [639:0]  hdr;
   logic [63:0]   target;
   logic          start;
   logic          stop;
   logic          core_busy;
   logic          nonce_found;
   logic [63:0]   nonce_in;

   miner_regs_if bus ();

   miner_regs #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .hdr         (hdr),
      .target      (target),
      .start       (start),
      .stop        (stop),
      .core_busy   (core_busy),
      .nonce_found (nonce_found),
      .nonce_in    (nonce_in)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  sb [$];
   logic [63:0] fm [$];
   bit          ovf_m;
   bit          wwb_m;
   logic [7:0]  held;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus.int_address = a;
      bus.int_wr_data = d;
      bus.int_write   = 1'b1;
      tick();
      bus.int_write   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] exp,
                     input string tag);
      sb.push_back(exp);
      bus.int_address = a;
      bus.int_read    = 1'b1;
      tick();
      bus.int_read    = 1'b0;
      chk(tag, 64'(bus.int_rd_data), 64'(sb.pop_front()));
   endtask

   task automatic m_push(input logic [63:0] n);
      if (fm.size() < DEPTH)
         fm.push_back(n);
      else
         ovf_m = 1'b1;
   endtask

   task automatic m_clear();
      fm.delete();
      ovf_m = 1'b0;
      wwb_m = 1'b0;
   endtask

   function automatic logic [7:0] m_byte(input int i);
      logic [63:0] h;
      if (fm.size() == 0)
         return 8'h00;
      h = fm[0];
      return h[8*i +: 8];
   endfunction

   function automatic logic [7:0] m_stat();
      return {3'b000, wwb_m, ovf_m, fm.size() == DEPTH,
              fm.size() == 0, core_busy};
   endfunction

   function automatic logic [63:0] mk(input int i);
      return 64'h8877_6655_4433_2200 | 64'(i);
   endfunction

   task automatic nonce(input logic [63:0] n);
      nonce_in    = n;
      nonce_found = 1'b1;
      tick();
      nonce_found = 1'b0;
      m_push(n);
   endtask

   task automatic drain_head(input string tag);
      for (int i = 0; i < 8; i++)
         rd(16'h0068 + 16'(i), m_byte(i), tag);
      if (fm.size() != 0)
         void'(fm.pop_front());
   endtask

   initial begin
      rst             = 1'b1;
      core_busy       = 1'b0;
      nonce_found     = 1'b0;
      nonce_in        = '0;
      bus.int_req     = 1'b0;
      bus.int_address = '0;
      bus.int_wr_data = '0;
      bus.int_write   = 1'b0;
      bus.int_read    = 1'b0;
      ovf_m           = 1'b0;
      wwb_m           = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 64'(bus.int_gnt), 0);
      chk("rst_rdata", 64'(bus.int_rd_data), 0);
      chk("rst_start", 64'(start), 0);
      chk("rst_stop", 64'(stop), 0);
      chk("rst_hdr", 64'(|hdr), 0);
      chk("rst_target", target, 0);

      rst = 1'b0;
      tick();
      chk("gnt_idle", 64'(bus.int_gnt), 0);
      bus.int_req = 1'b1;
      tick();
      chk("gnt_rise", 64'(bus.int_gnt), 1);

      rd(16'h0061, m_stat(), "stat_rst");
      rd(16'h0000, 8'h00, "hdr0_rst");

      wr(16'h004F, 8'hA5);
      chk("hdr_top", 64'(hdr[639:632]), 64'hA5);
      wr(16'h0050, 8'h3C);
      chk("tgt_low", 64'(target[7:0]), 64'h3C);
      rd(16'h004F, 8'hA5, "hdr_rb");
      rd(16'h0050, 8'h3C, "tgt_rb");
      held = 8'h3C;
      tick();
      chk("rd_hold", 64'(bus.int_rd_data), 64'(held));

      wr(16'h1000, 8'h77);
      rd(16'h1000, 8'h00, "unmapped_rd");
      rd(16'h0000, 8'h00, "unmapped_wr");
      rd(16'h0060, 8'h00, "ctrl_rd");

      core_busy = 1'b1;
      wr(16'h0000, 8'h11);
      wwb_m = 1'b1;
      chk("busy_hdr", 64'(hdr[7:0]), 0);
      wr(16'h0060, 8'h01);
      chk("busy_start", 64'(start), 0);
      rd(16'h0061, m_stat(), "stat_wwb");
      wr(16'h0060, 8'h04);
      m_clear();
      rd(16'h0061, m_stat(), "stat_wwb_clr");
      core_busy = 1'b0;

      wr(16'h0060, 8'h03);
      chk("both_stop", 64'(stop), 1);
      chk("both_start", 64'(start), 0);
      tick();
      chk("stop_pulse", 64'(stop), 0);
      wr(16'h0060, 8'h01);
      chk("start_hi", 64'(start), 1);
      chk("start_nostop", 64'(stop), 0);
      tick();
      chk("start_pulse", 64'(start), 0);

      for (int i = 1; i <= 5; i++)
         nonce(mk(i));
      rd(16'h0062, 8'(fm.size()), "cnt_full");
      rd(16'h0061, m_stat(), "stat_ovf");
      drain_head("head1");
      rd(16'h0062, 8'(fm.size()), "cnt_pop");
      rd(16'h0068, m_byte(0), "head2");
      rd(16'h006F, m_byte(7), "head2_pop");
      void'(fm.pop_front());
      rd(16'h0068, m_byte(0), "head3");

      wr(16'h0060, 8'h04);
      m_clear();
      for (int i = 10; i < 14; i++)
         nonce(mk(i));
      rd(16'h0061, m_stat(), "stat_full");

      sb.push_back(m_byte(7));
      bus.int_address = 16'h006F;
      bus.int_read    = 1'b1;
      nonce_in        = mk(20);
      nonce_found     = 1'b1;
      tick();
      bus.int_read    = 1'b0;
      nonce_found     = 1'b0;
      chk("pp_data", 64'(bus.int_rd_data), 64'(sb.pop_front()));
      void'(fm.pop_front());
      m_push(mk(20));
      rd(16'h0062, 8'(fm.size()), "pp_cnt");
      rd(16'h0061, m_stat(), "pp_stat");
      for (int k = 0; k < DEPTH; k++)
         drain_head("drain");
      rd(16'h006F, 8'h00, "empty_rd");
      rd(16'h0062, 8'h00, "empty_cnt");

      nonce(mk(30));
      bus.int_address = 16'h0060;
      bus.int_wr_data = 8'h04;
      bus.int_write   = 1'b1;
      nonce_in        = mk(31);
      nonce_found     = 1'b1;
      tick();
      bus.int_write   = 1'b0;
      nonce_found     = 1'b0;
      m_clear();
      rd(16'h0062, 8'h00, "clr_push_cnt");

      wr(16'h0057, 8'h5A);
      bus.int_address = 16'h0010;
      bus.int_wr_data = 8'hEE;
      bus.int_write   = 1'b1;
      #2;
      rst = 1'b1;
      tick();
      bus.int_write = 1'b0;
      chk("mid_rst_hdr", 64'(|hdr), 0);
      chk("mid_rst_tgt", target, 0);
      chk("mid_rst_gnt", 64'(bus.int_gnt), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_gnt", 64'(bus.int_gnt), 1);
      rd(16'h0061, m_stat(), "post_rst_stat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/miner_regs.md
# miner_regs

Internal-bus register block for the siaminer datapath, downstream of the UART parser. It decodes the parser's byte-wide, 16-bit-addressed read/write bus into three things: an 80-byte work header, a 64-bit target, and start/stop controls for the hash core. Nonces reported by the core are buffered in a small FIFO and read back over the same bus.

## Interface
- FIFO_DEPTH, 4: found-nonce FIFO depth in entries; power of two, 2 to 16.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- int_req  in  1  bus request from the parser.
- int_gnt  out  1  bus grant.
- int_address  in  16  byte address.
- int_wr_data  in  8  write data.
- int_write  in  1  write strobe, one cycle.
- int_read  in  1  read strobe, one cycle.
- int_rd_data  out  8  read data.
- hdr  out  640  work header; byte n is hdr[8n+7:8n].
- target  out  64  difficulty target; byte n is target[8n+7:8n].
- start  out  1  one-cycle start pulse to the core.
- stop  out  1  one-cycle stop pulse to the core.
- core_busy  in  1  the core is hashing.
- nonce_found  in  1  one-cycle valid for nonce_in.
- nonce_in  in  64  nonce that met the target.

## Operation
- Address map (only int_address[11:0] is decoded; addresses at or above 0x1000 are unmapped):
  - 0x000–0x04F: header bytes, read/write.
  - 0x050–0x057: target bytes, read/write.
  - 0x060: CTRL, write-only; reads return 0x00.
    - bit0: start.
    - bit1: stop.
    - bit2: FIFO clear.
  - 0x061: STATUS, read-only.
    - bit0: core_busy.
    - bit1: FIFO empty.
    - bit2: FIFO full.
    - bit3: overflow, sticky.
    - bit4: write-while-busy error, sticky.
    - bits7:5: reserved, read 0.
  - 0x062: FIFO count, read-only, zero-extended.
  - 0x068–0x06F: FIFO head nonce bytes, byte 0 at 0x068.
- Reads at unmapped addresses return 0x00. Writes there are ignored.
- Header and target writes while core_busy=1 are dropped and set the write-while-busy sticky bit.
- Start:
  - A CTRL write with bit0=1 while core_busy=0 pulses start.
  - With core_busy=1 it is ignored and sets the write-while-busy sticky bit.
- Stop: a CTRL write with bit1=1 pulses stop regardless of core_busy.
- If both bit0 and bit1 are set, stop wins and start is suppressed.
- FIFO clear (CTRL bit2=1):
  - empties the FIFO;
  - clears the overflow and write-while-busy sticky bits.
- FIFO push: on nonce_found.
  - When full, the nonce is dropped and overflow is set.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full; count is unchanged.
  - A clear and a push in the same cycle: clear wins, and count is 0.
- FIFO pop:
  - A read of 0x06F pops, after returning the current head byte.
  - Reads of 0x068–0x06E do not pop.
  - Any read of 0x068–0x06F with the FIFO empty returns 0x00 and does not pop.

## Timing
- Reset values:
  - int_gnt, int_rd_data, start, stop: 0.
  - hdr, target: 0.
  - FIFO: empty.
  - Sticky bits: 0.
- int_gnt is int_req registered: it rises 1 cycle after int_req and falls 1 cycle after int_req drops.
- Read latency: int_rd_data is registered and valid in cycle N+1 for int_read in cycle N. It holds until the next read.
- Writes to hdr/target are visible on the outputs in cycle N+1.
- start/stop pulses are high exactly in cycle N+1 after the CTRL write.
- A nonce_found in cycle N shows in STATUS and count for a read issued in cycle N+1.
- Reset asserted mid-transaction aborts it and all state returns to reset values. Behaviour resumes on the first clk edge after rst deasserts.

## Structure
- Shared package/header miner_regs_defs: address constants, CTRL/STATUS bit indices, HDR_BYTES=80, TARGET_BYTES=8.
- One sub-module, nonce_fifo:
  - synchronous FIFO, 64-bit wide, FIFO_DEPTH deep;
  - ports: push, pop, clr, din, dout, full, empty, count;
  - pointer wrap modulo FIFO_DEPTH.
- Top level contains the decoder, register storage, pulse generation and sticky bits.

## Test plan
- Reset, then read 0x061 → 0x02 (empty). Read 0x000 → 0x00. int_gnt=0 until int_req.
- Write 0xA5 to 0x04F and 0x3C to 0x050, then read them back → 0xA5 and 0x3C. hdr[639:632]=0xA5 and target[7:0]=0x3C on the next cycle.
- With core_busy=1, write 0x11 to 0x000 and 0x01 to 0x060 → hdr unchanged, no start, STATUS bit4=1. Write 0x04 to 0x060 → bit4 clears.
- With core_busy=0, write 0x03 to 0x060 → stop high for exactly 1 cycle, start stays 0.
- Push 5 nonces 0x1…0x5 with FIFO_DEPTH=4 → count 4, STATUS=0x0C (full and overflow, core_busy=0). Reading 0x068–0x06F returns the bytes of 0x1 and the 0x06F read pops. The next head is 0x2 and 0x5 is lost.
- With the FIFO full, assert nonce_found in the same cycle as the 0x06F read → count stays 4, overflow not newly set, the new nonce lands at the tail.
